ahb_sram_ecc: RTL and testbench
===============================

# ahb_sram_ecc

- AHB-Lite single-port-slave SRAM that sits directly downstream of the core's instruction or data bus.
- Stores each 32-bit word together with its 7-bit SEC-DED checksum.
- Verifies the core's outgoing write checksum and address-phase parity, and returns stored data plus checksum, so the core's bus protection is end-to-end.
- Zero wait states for every valid transfer; protocol, parity, checksum and range violations produce a two-cycle AHB ERROR response.

## Interface
Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two; AW = $clog2(MEM_WORDS).

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset; one clock; reset is synchronous and active-low
- s_hsel_i  in  1  slave select
- s_haddr_i  in  32  address
- s_htrans_i  in  2  transfer type
- s_hwrite_i  in  1  write indicator
- s_hsize_i  in  3  size: 0 byte, 1 half, 2 word
- s_hwdata_i  in  32  write data (data phase)
- s_hwchecksum_i  in  7  SEC-DED checksum of s_hwdata_i (data phase)
- s_hparity_i  in  6  address-phase parity
- s_hready_i  in  1  bus ready (accept address phase when 1)
- s_hrdata_o  out  32  read data
- s_hrchecksum_o  out  7  stored checksum of s_hrdata_o
- s_hreadyout_o  out  1  slave ready
- s_hresp_o  out  1  error response
- s_err_cnt_o  out  8  saturating count of ERROR responses issued

## Operation
- Address phase accepted when s_hsel_i & s_htrans_i[1] & s_hready_i. IDLE/BUSY transfers get OKAY with no memory action.
- Every accepted phase captures addr, write, size and byte lanes into data-phase registers, and issues a synchronous read of word haddr[AW+1:2].
- Parity check is even parity:
  - s_hparity_i[k] = ^haddr[8k+7:8k] for k=0..3
  - [4] = ^htrans
  - [5] = ^{hwrite,hsize}
- Address-phase error, flagged to the data phase, on any of:
  - parity mismatch
  - haddr[31:AW+2] != 0
  - hsize > 2
  - misaligned address (half: addr[0]; word: addr[1:0])
- Data phase, flagged: no memory write; ERROR response.
- Data phase, read: s_hrdata_o and s_hrchecksum_o present the stored word and checksum unmodified. The slave never corrects data; correction belongs to the core.
- Data phase, write:
  - Recompute the SEC-DED checksum of s_hwdata_i. On mismatch with s_hwchecksum_i: no write; ERROR response.
  - Otherwise merge the enabled byte lanes of s_hwdata_i into the old word (read launched in the address phase), compute the checksum of the merged word, and write word+checksum at the end of the cycle.
- Read-after-write bypass: if the address phase in the same cycle targets the word being written, the next-cycle read data/checksum is the merged word and its new checksum.
- State machine:
  - OK → ERR1 when a flagged or checksum-failed data phase occurs.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → OK, or ERR1 if the address phase accepted in ERR2 is itself erroneous.
- Outputs per state:
  - OK: hreadyout=1, hresp=0
  - ERR1: hreadyout=0, hresp=1; the address phase is not accepted because s_hready_i=0
  - ERR2: hreadyout=1, hresp=1
- s_err_cnt_o increments on entry to ERR1 and saturates at 255.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, hrchecksum=0, err_cnt=0, state OK, no pending data phase. Memory contents are not reset.
- Reset asserted mid-transfer: the pending data phase is discarded and its write is not performed.
- Read latency: data valid in the cycle after the address phase, i.e. the data phase.
- Write: the memory updates on the clock edge ending the data phase.
- Back-to-back writes and reads to the same word are fully supported without stall.
- An error response is exactly two cycles long; the ERROR does not consume the following address phase until ERR2.

## Structure
- p_hardisc package holds:
  - the SEC-DED encoder function (32→7), shared with the core's bus-protection logic
  - the parity-group function
  - the ahb_err_state_t enum (OK, ERR1, ERR2)
- One sub-module, sram_1r1w: MEM_WORDS x 39 bit, synchronous read, synchronous write, read-during-write returns old data. Bypass lives in the top module.

## Test plan
- Write word 0xDEADBEEF with correct checksum to 0x10, then read 0x10 → hrdata=0xDEADBEEF and hrchecksum=enc(0xDEADBEEF); hreadyout=1 throughout.
- Word 0x11223344 at 0x20, then byte write 0xAA at 0x21, then read 0x20 immediately back-to-back → hrdata=0x1122AA44, checksum=enc(0x1122AA44) via bypass.
- Write with s_hwchecksum_i bit 0 flipped → ERR1 (hreadyout=0, hresp=1), then ERR2 (1,1); memory unchanged; err_cnt=1.
- Address phase with s_hparity_i[2] flipped, then haddr=0x0000_1000 with MEM_WORDS=1024, then half-word at 0x3 → three ERROR sequences; err_cnt=3.
- Reset asserted during a write data phase → outputs return to reset values next cycle; a later read of that word returns the prior contents.
- Force err_cnt to 255, then provoke one more error → err_cnt stays 255.

Source files
------------

// File: rtl/ahb_sram_ecc_pkg.sv
// -----------------------------------------------------------------------------
// p_hardisc: definitions shared between the core's bus-protection logic and the
// SRAM slave.
//   secded_enc  : 32-bit data -> 7-bit SEC-DED checksum (extended Hamming:
//                 data bits occupy the non-power-of-two positions 1..38, check
//                 bit k covers every position with bit k set, bit 6 is overall
//                 parity of data and check bits)
//   ahb_parity  : even parity groups protecting the AHB address phase
//   ahb_err_state_t : response state of the slave (OK, ERR1, ERR2)
// -----------------------------------------------------------------------------
package p_hardisc;

    typedef enum logic [1:0] {
        OK   = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } ahb_err_state_t;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ECC_W  = 7;

    function automatic logic [6:0] secded_enc(input logic [31:0] data);
        logic [6:0] chk;
        logic [5:0] di;
        chk = 7'd0;
        di  = 6'd0;
        for (logic [5:0] pos = 6'd1; pos <= 6'd38; pos = pos + 6'd1) begin
            // Power-of-two positions hold check bits, the rest hold data.
            if ((pos & (pos - 6'd1)) != 6'd0) begin
                chk[5:0] = chk[5:0] ^ (pos & {6{data[di[4:0]]}});
                di       = di + 6'd1;
            end
        end
        chk[6] = (^data) ^ (^chk[5:0]);
        return chk;
    endfunction

    function automatic logic [5:0] ahb_parity(input logic [31:0] addr,
                                              input logic [1:0]  trans,
                                              input logic        write,
                                              input logic [2:0]  size);
        logic [5:0] par;
        par[0] = ^addr[7:0];
        par[1] = ^addr[15:8];
        par[2] = ^addr[23:16];
        par[3] = ^addr[31:24];
        par[4] = ^trans;
        par[5] = ^{write, size};
        return par;
    endfunction

endpackage

// File: rtl/ahb_sram_ecc_sram_1r1w.sv
// -----------------------------------------------------------------------------
// sram_1r1w: WORDS x WIDTH memory, one synchronous read port and one
// synchronous write port. A read of the word being written in the same cycle
// returns the old contents. Contents are not reset.
//   clk         clock
//   re / raddr  read enable and word address; rdata valid the next cycle
//   we / waddr / wdata  write enable, word address and data
// -----------------------------------------------------------------------------
module sram_1r1w #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned WIDTH = 39,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);

    logic [WIDTH-1:0] mem_r [WORDS];
    logic [WIDTH-1:0] rdata_r;

    // Storage array write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/ahb_sram_ecc.sv
// -----------------------------------------------------------------------------
// ahb_sram_ecc: zero-wait-state AHB-Lite SRAM slave storing 32-bit words with
// their SEC-DED checksum. Write checksums and address-phase parity coming from
// the core are verified; read data is returned with its stored checksum and is
// never corrected here. Violations give a two-cycle ERROR response.
//   s_clk_i, s_resetn_i           clock, synchronous active-low reset
//   s_hsel_i .. s_hready_i        AHB address phase (+ parity) and data phase
//   s_hwdata_i, s_hwchecksum_i    write data and its checksum
//   s_hrdata_o, s_hrchecksum_o    read data and its stored checksum
//   s_hreadyout_o, s_hresp_o      slave response
//   s_err_cnt_o                   saturating count of ERROR responses
// -----------------------------------------------------------------------------
module ahb_sram_ecc
    import p_hardisc::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic        s_hwrite_i,
    input  logic [2:0]  s_hsize_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [6:0]  s_hwchecksum_i,
    input  logic [5:0]  s_hparity_i,
    input  logic        s_hready_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrchecksum_o,
    output logic        s_hreadyout_o,
    output logic        s_hresp_o,
    output logic [7:0]  s_err_cnt_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned HW = 30 - AW;

    ahb_err_state_t state_r, state_s, state_nxt_s;

    logic          dp_valid_r, dp_write_r, dp_err_r;
    logic [AW-1:0] dp_addr_r;
    logic [3:0]    dp_lanes_r;
    logic          byp_valid_r;
    logic [38:0]   byp_word_r;
    logic [7:0]    err_cnt_r;

    logic          accept_s, addr_err_s, par_err_s, range_err_s, size_err_s, align_err_s;
    logic [AW-1:0] word_idx_s;
    logic [3:0]    lanes_s;
    logic [38:0]   mem_rdata_s, old_word_s;
    logic [31:0]   lane_mask_s, merged_s;
    logic [6:0]    merged_chk_s;
    logic          chk_bad_s, wr_ok_s, wr_fail_s, we_s, rd_phase_s;

    // Address-phase decode: target word, byte lanes and protocol/parity checks.
    always_comb begin
        word_idx_s  = s_haddr_i[AW+1:2];
        par_err_s   = (ahb_parity(s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i) != s_hparity_i);
        range_err_s = (s_haddr_i[31:AW+2] != {HW{1'b0}});
        size_err_s  = (s_hsize_i > 3'd2);
        align_err_s = 1'b0;
        lanes_s     = 4'b0000;
        case (s_hsize_i)
            3'd0: lanes_s = 4'b0001 << s_haddr_i[1:0];
            3'd1: begin
                align_err_s = s_haddr_i[0];
                lanes_s     = s_haddr_i[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                align_err_s = |s_haddr_i[1:0];
                lanes_s     = 4'b1111;
            end
            default: lanes_s = 4'b0000;
        endcase
        addr_err_s = par_err_s | range_err_s | size_err_s | align_err_s;
    end

    // Data-phase datapath: old word (with bypass), lane merge, checksum checks.
    always_comb begin
        if (byp_valid_r) begin
            old_word_s = byp_word_r;
        end else begin
            old_word_s = mem_rdata_s;
        end
        lane_mask_s  = {{8{dp_lanes_r[3]}}, {8{dp_lanes_r[2]}},
                        {8{dp_lanes_r[1]}}, {8{dp_lanes_r[0]}}};
        merged_s     = (s_hwdata_i & lane_mask_s) | (old_word_s[31:0] & ~lane_mask_s);
        merged_chk_s = secded_enc(merged_s);
        chk_bad_s    = (secded_enc(s_hwdata_i) != s_hwchecksum_i);
        wr_ok_s      = dp_valid_r & dp_write_r & ~dp_err_r;
        wr_fail_s    = wr_ok_s & chk_bad_s;
        // A write whose data phase coincides with reset is dropped.
        we_s         = wr_ok_s & ~chk_bad_s & s_resetn_i;
        rd_phase_s   = dp_valid_r & ~dp_write_r & ~dp_err_r;
    end

    // Response state: a checksum failure is only visible in the data phase,
    // so it forces ERR1 in that same cycle on top of the registered state.
    always_comb begin
        if (wr_fail_s) begin
            state_s = ERR1;
        end else begin
            state_s = state_r;
        end
        accept_s    = s_hsel_i & s_htrans_i[1] & s_hready_i & (state_s != ERR1);
        state_nxt_s = OK;
        case (state_s)
            OK:      state_nxt_s = (accept_s & addr_err_s) ? ERR1 : OK;
            ERR1:    state_nxt_s = ERR2;
            ERR2:    state_nxt_s = (accept_s & addr_err_s) ? ERR1 : OK;
            default: state_nxt_s = OK;
        endcase
    end

    // Bus outputs decoded from the response state and the pending read.
    always_comb begin
        s_hreadyout_o = (state_s != ERR1);
        s_hresp_o     = (state_s != OK);
        if (rd_phase_s) begin
            s_hrdata_o     = old_word_s[31:0];
            s_hrchecksum_o = old_word_s[38:32];
        end else begin
            s_hrdata_o     = 32'd0;
            s_hrchecksum_o = 7'd0;
        end
    end

    // State, data-phase capture, read-after-write bypass and error counter.
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            state_r     <= OK;
            dp_valid_r  <= 1'b0;
            dp_write_r  <= 1'b0;
            dp_err_r    <= 1'b0;
            dp_addr_r   <= {AW{1'b0}};
            dp_lanes_r  <= 4'b0000;
            byp_valid_r <= 1'b0;
            byp_word_r  <= 39'd0;
            err_cnt_r   <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            dp_valid_r <= accept_s;
            if (accept_s) begin
                dp_addr_r  <= word_idx_s;
                dp_write_r <= s_hwrite_i;
                dp_lanes_r <= lanes_s;
                dp_err_r   <= addr_err_s;
            end
            // The SRAM returns the pre-write word for a same-word read, so the
            // freshly merged word is held for the next data phase instead.
            byp_valid_r <= we_s & accept_s & (word_idx_s == dp_addr_r);
            byp_word_r  <= {merged_chk_s, merged_s};
            if ((state_s == ERR1) && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign s_err_cnt_o = err_cnt_r;

    sram_1r1w #(
        .WORDS (MEM_WORDS),
        .WIDTH (39)
    ) u_sram (
        .clk   (s_clk_i),
        .re    (accept_s),
        .raddr (word_idx_s),
        .rdata (mem_rdata_s),
        .we    (we_s),
        .waddr (dp_addr_r),
        .wdata ({merged_chk_s, merged_s})
    );

endmodule

// File: tb/tb_ahb_sram_ecc.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for ahb_sram_ecc. The driver issues directed AHB transfers
// and queues the response expected in a given cycle; a monitor running on the
// falling edge pops entries due in that cycle and compares them.
// -----------------------------------------------------------------------------
module tb_ahb_sram_ecc;

    logic        clk = 1'b0;
    logic        s_resetn, s_hsel, s_hwrite, s_hready, s_hreadyout, s_hresp;
    logic [31:0] s_haddr, s_hwdata, s_hrdata;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;
    logic [6:0]  s_hwchecksum, s_hrchecksum;
    logic [5:0]  s_hparity;
    logic [7:0]  s_err_cnt;

    always #5 clk = ~clk;

    ahb_sram_ecc #(.MEM_WORDS(1024)) dut (
        .s_clk_i        (clk),
        .s_resetn_i     (s_resetn),
        .s_hsel_i       (s_hsel),
        .s_haddr_i      (s_haddr),
        .s_htrans_i     (s_htrans),
        .s_hwrite_i     (s_hwrite),
        .s_hsize_i      (s_hsize),
        .s_hwdata_i     (s_hwdata),
        .s_hwchecksum_i (s_hwchecksum),
        .s_hparity_i    (s_hparity),
        .s_hready_i     (s_hready),
        .s_hrdata_o     (s_hrdata),
        .s_hrchecksum_o (s_hrchecksum),
        .s_hreadyout_o  (s_hreadyout),
        .s_hresp_o      (s_hresp),
        .s_err_cnt_o    (s_err_cnt)
    );

    // Single slave on the bus: the bus ready is the slave's own ready.
    assign s_hready = s_hreadyout;

    typedef struct packed {
        logic [31:0] cyc;
        logic        chk_resp;
        logic        ready;
        logic        resp;
        logic        chk_data;
        logic [31:0] data;
        logic [6:0]  dchk;
        logic        chk_cnt;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    string       sb_name[$];
    logic [31:0] cyc = 32'd0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pend_wdata;
    logic [6:0]  pend_wchk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Reference checksum: lay the data into a 38-position codeword, then take
    // each check bit as the parity of the positions it covers.
    function automatic logic [6:0] ref_enc(input logic [31:0] d);
        logic [38:1] cw;
        logic [6:0]  c;
        logic [4:0]  k;
        cw = '0;
        c  = 7'd0;
        k  = 5'd0;
        for (logic [5:0] p = 6'd1; p <= 6'd38; p = p + 6'd1) begin
            if (p != 6'd1 && p != 6'd2 && p != 6'd4 && p != 6'd8 && p != 6'd16 && p != 6'd32) begin
                cw[p] = d[k];
                k     = k + 5'd1;
            end
        end
        for (logic [2:0] i = 3'd0; i < 3'd6; i = i + 3'd1) begin
            for (logic [5:0] p = 6'd1; p <= 6'd38; p = p + 6'd1) begin
                if (p[i]) c[i] = c[i] ^ cw[p];
            end
        end
        c[6] = (^d) ^ (^c[5:0]);
        return c;
    endfunction

    function automatic logic [5:0] ref_par(input logic [31:0] a, input logic [1:0] t,
                                           input logic w, input logic [2:0] s);
        return {^{w, s}, ^t, ^a[31:24], ^a[23:16], ^a[15:8], ^a[7:0]};
    endfunction

    task automatic push(input logic [31:0] at, input string nm, input logic cr, input logic rdy,
                        input logic rsp, input logic cd, input logic [31:0] d, input logic [6:0] dc,
                        input logic cc, input logic [7:0] cn);
        exp_t e;
        e.cyc = at; e.chk_resp = cr; e.ready = rdy; e.resp = rsp;
        e.chk_data = cd; e.data = d; e.dchk = dc; e.chk_cnt = cc; e.cnt = cn;
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare every entry due in the current cycle.
    initial begin
        exp_t e;
        string nm;
        int i;
        forever begin
            @(negedge clk);
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].cyc <= cyc) begin
                    e  = sb[i];
                    nm = sb_name[i];
                    sb.delete(i);
                    sb_name.delete(i);
                    if (e.cyc != cyc) check(nm, "cycle", cyc, e.cyc);
                    if (e.chk_resp) begin
                        check(nm, "hreadyout", 32'(s_hreadyout), 32'(e.ready));
                        check(nm, "hresp", 32'(s_hresp), 32'(e.resp));
                    end
                    if (e.chk_data) begin
                        check(nm, "hrdata", s_hrdata, e.data);
                        check(nm, "hrchecksum", 32'(s_hrchecksum), 32'(e.dchk));
                    end
                    if (e.chk_cnt) check(nm, "err_cnt", 32'(s_err_cnt), 32'(e.cnt));
                end else begin
                    i++;
                end
            end
        end
    end

    // Advance one cycle and drive the pending write data for its data phase.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        s_hwdata     = pend_wdata;
        s_hwchecksum = pend_wchk;
        pend_wdata   = 32'd0;
        pend_wchk    = 7'd0;
    endtask

    task automatic idle();
        next_cycle();
        s_hsel   = 1'b0;
        s_htrans = 2'b00;
        s_haddr  = 32'd0;
        s_hwrite = 1'b0;
        s_hsize  = 3'd0;
        s_hparity = ref_par(32'd0, 2'b00, 1'b0, 3'd0);
    endtask

    // Issue a NONSEQ transfer; queue the data-phase response (and data for reads).
    task automatic issue(input string nm, input logic wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [6:0] wchk,
                         input logic [5:0] par_flip, input logic exp_err, input logic [31:0] exp_rd);
        next_cycle();
        s_hsel    = 1'b1;
        s_htrans  = 2'b10;
        s_hwrite  = wr;
        s_hsize   = size;
        s_haddr   = addr;
        s_hparity = ref_par(addr, 2'b10, wr, size) ^ par_flip;
        pend_wdata = wdata;
        pend_wchk  = wchk;
        if (exp_err) begin
            push(cyc + 32'd1, {nm, "_err1"}, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 7'd0, 1'b0, 8'd0);
            push(cyc + 32'd2, {nm, "_err2"}, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 7'd0, 1'b0, 8'd0);
        end else begin
            push(cyc + 32'd1, nm, 1'b1, 1'b1, 1'b0, !wr, exp_rd, ref_enc(exp_rd), 1'b0, 8'd0);
        end
    endtask

    task automatic wr(input string nm, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] d);
        issue(nm, 1'b1, size, addr, d, ref_enc(d), 6'd0, 1'b0, 32'd0);
    endtask

    task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] exp_d);
        issue(nm, 1'b0, 3'd2, addr, 32'd0, 7'd0, 6'd0, 1'b0, exp_d);
    endtask

    task automatic rd_err(input string nm, input logic [2:0] size, input logic [31:0] addr, input logic [5:0] flip);
        issue(nm, 1'b0, size, addr, 32'd0, 7'd0, flip, 1'b1, 32'd0);
    endtask

    task automatic check_cnt(input string nm, input logic [7:0] exp_cnt);
        push(cyc, nm, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 7'd0, 1'b1, exp_cnt);
    endtask

    task automatic check_reset_state(input string nm);
        push(cyc, nm, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 7'd0, 1'b1, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_resetn = 1'b0;
        s_hsel = 1'b0; s_htrans = 2'b00; s_haddr = 32'd0; s_hwrite = 1'b0; s_hsize = 3'd0;
        s_hparity = 6'd0; s_hwdata = 32'd0; s_hwchecksum = 7'd0;
        pend_wdata = 32'd0; pend_wchk = 7'd0;
        idle(); idle(); idle();
        check_reset_state("reset");
        s_resetn = 1'b1;

        // Word write then back-to-back read (bypass), then read from the array.
        wr("wr_10", 3'd2, 32'h10, 32'hDEADBEEF);
        rd("rd_10_byp", 32'h10, 32'hDEADBEEF);
        idle();
        rd("rd_10_mem", 32'h10, 32'hDEADBEEF);
        idle();

        // Word, then byte lane 1, then read: each step merges over the previous.
        wr("wr_20", 3'd2, 32'h20, 32'h11223344);
        wr("wr_21_byte", 3'd0, 32'h21, 32'h0000AA00);
        rd("rd_20_byp", 32'h20, 32'h1122AA44);
        wr("wr_22_half", 3'd1, 32'h22, 32'hBEEF0000);
        idle();
        rd("rd_20_half", 32'h20, 32'hBEEFAA44);
        rd("rd_10_again", 32'h10, 32'hDEADBEEF);
        idle();

        // Write with a corrupted checksum: ERROR, memory untouched.
        issue("wr_badchk", 1'b1, 3'd2, 32'h10, 32'h12345678, ref_enc(32'h12345678) ^ 7'h01,
              6'd0, 1'b1, 32'd0);
        idle(); idle();
        check_cnt("cnt_1", 8'd1);
        rd("rd_10_kept", 32'h10, 32'hDEADBEEF);
        idle();

        // Parity, range and alignment errors, the second one issued during ERR2.
        rd_err("par_flip2", 3'd2, 32'h30, 6'b000100);
        idle();
        rd_err("range_1000", 3'd2, 32'h0000_1000, 6'd0);
        idle();
        rd_err("half_mis3", 3'd1, 32'h3, 6'd0);
        idle(); idle();
        check_cnt("cnt_4", 8'd4);
        rd_err("size3", 3'd3, 32'h40, 6'd0);
        idle();
        rd_err("word_mis2", 3'd2, 32'h42, 6'd0);
        idle(); idle();
        check_cnt("cnt_6", 8'd6);
        rd("rd_after_err", 32'h20, 32'hBEEFAA44);
        idle();

        // Reset during a write data phase: write dropped, outputs back to reset.
        wr("wr_20_rst", 3'd2, 32'h20, 32'hCAFEF00D);
        next_cycle();
        s_resetn = 1'b0;
        s_hsel   = 1'b0;
        s_htrans = 2'b00;
        next_cycle();
        check_reset_state("reset_mid");
        s_resetn = 1'b1;
        rd("rd_20_rst", 32'h20, 32'hBEEFAA44);
        idle();

        // Counter saturation.
        for (int n = 0; n < 256; n++) begin
            rd_err("sat", 3'd2, 32'h50, 6'b100000);
            idle();
        end
        idle();
        check_cnt("cnt_255", 8'd255);
        rd_err("sat_extra", 3'd2, 32'h50, 6'b000001);
        idle(); idle();
        check_cnt("cnt_stays", 8'd255);
        rd("rd_final", 32'h10, 32'hDEADBEEF);
        idle(); idle();

        for (int w = 0; w < 50 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
